// File: rtl/sse_accum_n.sv
// Streaming sum of squared (mode 0) or absolute (mode 1) error over IEEE-754 single pairs.
// Optional sticky NaN output enabled by defining SSE_ACCUM_NAN_FLAG_EN.
package sse_fp_pkg;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Round-to-nearest-even, then pack; subnormal results flush to signed zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [23:0] m, input logic g, input logic st);
    logic [24:0]        r;
    logic signed [9:0]  ef;
    r  = {1'b0, m} + {24'd0, g & (st | m[0])};
    ef = r[24] ? e + 10'sd1 : e;
    if (ef >= 10'sd255)    return {s, 8'hFF, 23'd0};
    else if (ef <= 10'sd0) return {s, 31'd0};
    else                   return {s, ef[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction
endpackage

module adder_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [31:0] y
);
  import sse_fp_pkg::*;
  logic [31:0] opa_q, opb_q, y_q, res;
  logic        busy_q, ready_q;
  logic        sl, ss, st;
  logic [7:0]  ea, eb, el, es, diff;
  logic [23:0] ma, mb, ml, ms;
  logic [49:0] xl, xs0, xs, sum;
  logic [48:0] nrm;
  logic [5:0]  lz;
  logic [9:0]  ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q <= '0; opb_q <= '0; y_q <= '0; busy_q <= 1'b0; ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (start && !busy_q) begin
        opa_q  <= a;
        opb_q  <= {b[31] ^ op, b[30:0]};
        busy_q <= 1'b1;
      end else if (busy_q) begin
        y_q     <= res;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    ea = opa_q[30:23];
    eb = opb_q[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, opa_q[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, opb_q[22:0]};
    if ({eb, mb} > {ea, ma}) begin
      sl = opb_q[31]; el = eb; ml = mb; ss = opa_q[31]; es = ea; ms = ma;
    end else begin
      sl = opa_q[31]; el = ea; ml = ma; ss = opb_q[31]; es = eb; ms = mb;
    end
    diff = el - es;
    xl   = {1'b0, ml, 25'd0};
    xs0  = {1'b0, ms, 25'd0};
    xs   = (diff > 8'd49) ? 50'd0 : (xs0 >> diff);
    st   = (diff > 8'd49) ? (ms != 24'd0) : ((xs << diff) != xs0);
    sum  = (sl != ss) ? (xl - xs - {49'd0, st}) : (xl + xs);
    sum[0] = sum[0] | st;
    lz = 6'd0;
    for (int i = 0; i < 50; i++) if (sum[i]) lz = 6'(i);
    nrm = (lz == 6'd49) ? (sum[49:1] | {48'd0, sum[0]}) : 49'(sum << (6'd48 - lz));
    ex  = {2'b0, el} + {4'd0, lz} - 10'd48;
    if (is_nan(opa_q) || is_nan(opb_q) ||
        (ea == 8'hFF && eb == 8'hFF && opa_q[31] != opb_q[31])) res = QNAN;
    else if (ea == 8'hFF) res = opa_q;
    else if (eb == 8'hFF) res = opb_q;
    else if (sum == 50'd0) res = 32'd0;
    else res = fp_pack(sl, ex, nrm[48:25], nrm[24], |nrm[23:0]);
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign y     = y_q;
endmodule

module multiplier_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [31:0] y
);
  import sse_fp_pkg::*;
  logic [31:0] opa_q, opb_q, y_q, res;
  logic        busy_q, ready_q, s, za, zb, ia, ib;
  logic [7:0]  ea, eb;
  logic [47:0] prod, n;
  logic [9:0]  ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q <= '0; opb_q <= '0; y_q <= '0; busy_q <= 1'b0; ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (start && !busy_q) begin
        opa_q  <= a;
        opb_q  <= b;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        y_q     <= res;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    s    = opa_q[31] ^ opb_q[31];
    ea   = opa_q[30:23];
    eb   = opb_q[30:23];
    za   = (ea == 8'd0);
    zb   = (eb == 8'd0);
    ia   = (ea == 8'hFF) && (opa_q[22:0] == 23'd0);
    ib   = (eb == 8'hFF) && (opb_q[22:0] == 23'd0);
    prod = {24'd0, 1'b1, opa_q[22:0]} * {24'd0, 1'b1, opb_q[22:0]};
    n    = prod[47] ? prod : {prod[46:0], 1'b0};
    ex   = {2'b0, ea} + {2'b0, eb} - 10'd127 + {9'd0, prod[47]};
    if (is_nan(opa_q) || is_nan(opb_q) || (ia && zb) || (ib && za)) res = QNAN;
    else if (ia || ib) res = {s, 8'hFF, 23'd0};
    else if (za || zb) res = {s, 31'd0};
    else res = fp_pack(s, ex, n[47:24], n[23], |n[22:0]);
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign y     = y_q;
endmodule

// state | meaning
// IDLE  | waiting for an element pair (in_ready=1)
// SUB   | a-b in flight
// TERM  | d*d in flight (mode 0 only)
// ACC   | acc+term in flight
// DONE  | result presented until out_ready
module sse_accum_n #(
  parameter int CNT_W    = 16,
  parameter int MODE_DEF = 0
) (
`ifdef SSE_ACCUM_NAN_FLAG_EN
  output logic             nan_flag,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             in_last,
  input  logic             mode_ovr,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [CNT_W-1:0] count
);
  import sse_fp_pkg::*;
  typedef enum logic [2:0] {IDLE, SUB, TERM, ACC, DONE} state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q, d_q, term_q, acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q, mode_q, in_ready_q, out_valid_q;
  logic               sub_start_q, mul_start_q, acc_start_q;
  logic               sub_pend_q, mul_pend_q, acc_pend_q;
  logic               sub_busy, sub_ready, mul_busy, mul_ready, acc_busy, acc_ready;
  logic [31:0]        sub_y, mul_y, acc_y;
`ifdef SSE_ACCUM_NAN_FLAG_EN
  logic               nan_q;
`endif

  adder_fp u_sub (.clk(clk), .rst(rst), .start(sub_start_q), .op(1'b1), .a(a_q), .b(b_q),
                  .busy(sub_busy), .ready(sub_ready), .y(sub_y));
  multiplier_fp u_mul (.clk(clk), .rst(rst), .start(mul_start_q), .a(d_q), .b(d_q),
                       .busy(mul_busy), .ready(mul_ready), .y(mul_y));
  adder_fp u_acc (.clk(clk), .rst(rst), .start(acc_start_q), .op(1'b0), .a(acc_q), .b(term_q),
                  .busy(acc_busy), .ready(acc_ready), .y(acc_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0; b_q <= '0; d_q <= '0; term_q <= '0; acc_q <= '0; cnt_q <= '0;
      last_q <= 1'b0; mode_q <= 1'b0; in_ready_q <= 1'b0; out_valid_q <= 1'b0;
      sub_start_q <= 1'b0; mul_start_q <= 1'b0; acc_start_q <= 1'b0;
      sub_pend_q <= 1'b0; mul_pend_q <= 1'b0; acc_pend_q <= 1'b0;
`ifdef SSE_ACCUM_NAN_FLAG_EN
      nan_q <= 1'b0;
`endif
    end else begin
      sub_start_q <= 1'b0;
      mul_start_q <= 1'b0;
      acc_start_q <= 1'b0;
      // A start that met a busy unit is replayed once the unit frees up.
      if (sub_pend_q && !sub_busy) begin sub_start_q <= 1'b1; sub_pend_q <= 1'b0; end
      if (mul_pend_q && !mul_busy) begin mul_start_q <= 1'b1; mul_pend_q <= 1'b0; end
      if (acc_pend_q && !acc_busy) begin acc_start_q <= 1'b1; acc_pend_q <= 1'b0; end
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q <= a; b_q <= b; last_q <= in_last;
            mode_q     <= mode_ovr ? mode : MODE_DEF[0];
            in_ready_q <= 1'b0;
            if (sub_busy) sub_pend_q <= 1'b1; else sub_start_q <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: if (sub_ready) begin
          d_q <= sub_y;
          if (!mode_q) begin
            if (mul_busy) mul_pend_q <= 1'b1; else mul_start_q <= 1'b1;
            state_q <= TERM;
          end else begin
            term_q <= {1'b0, sub_y[30:0]};
`ifdef SSE_ACCUM_NAN_FLAG_EN
            nan_q <= nan_q | is_nan(sub_y);
`endif
            if (acc_busy) acc_pend_q <= 1'b1; else acc_start_q <= 1'b1;
            state_q <= ACC;
          end
        end
        TERM: if (mul_ready) begin
          term_q <= mul_y;
`ifdef SSE_ACCUM_NAN_FLAG_EN
          nan_q <= nan_q | is_nan(mul_y);
`endif
          if (acc_busy) acc_pend_q <= 1'b1; else acc_start_q <= 1'b1;
          state_q <= ACC;
        end
        ACC: if (acc_ready) begin
          acc_q <= acc_y;
`ifdef SSE_ACCUM_NAN_FLAG_EN
          nan_q <= nan_q | is_nan(acc_y);
`endif
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
          if (last_q) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DONE: if (out_ready) begin
          acc_q <= '0; cnt_q <= '0;
`ifdef SSE_ACCUM_NAN_FLAG_EN
          nan_q <= 1'b0;
`endif
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = acc_q;
  assign count     = cnt_q;
`ifdef SSE_ACCUM_NAN_FLAG_EN
  assign nan_flag  = nan_q;
`endif
endmodule

// File: tb/tb_sse_accum_n.sv
// Scoreboard bench for sse_accum_n: directed vectors, expected results queued at issue time.
`timescale 1ns/1ps
module tb_sse_accum_n;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, mode_ovr = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [31:0] y;
  logic [15:0] count;
`ifdef SSE_ACCUM_NAN_FLAG_EN
  logic        nan_flag;
`endif

  sse_accum_n #(.CNT_W(16), .MODE_DEF(0)) dut (
`ifdef SSE_ACCUM_NAN_FLAG_EN
    .nan_flag(nan_flag),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_last(in_last), .mode_ovr(mode_ovr), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .count(count));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] y; logic [15:0] cnt; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic seen = 1'b0;
  int   errors = 0, checks = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) seen = 1'b0;
    else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: y=%h count=%0d, none required", y, count);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_y", 48'(y), 48'(mon_e.y));
        check("result_count", 48'(count), 48'(mon_e.cnt));
      end
    end else if (!out_valid) seen = 1'b0;
  end

  task automatic push_exp(input logic [31:0] ey, input logic [15:0] ec);
    sb_q.push_back({ey, ec});
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tl,
                      input logic to, input logic tm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=0, required 1");
    end else begin
      a = ta; b = tb_v; in_last = tl; mode_ovr = to; mode = tm; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: out_valid=0, required 1");
    end
  endtask

  task automatic release_chk();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("clear_y", 48'(y), 48'h0);
    check("clear_count", 48'(count), 48'h0);
    check("clear_in_ready", 48'(in_ready), 48'h1);
    check("clear_out_valid", 48'(out_valid), 48'h0);
`ifdef SSE_ACCUM_NAN_FLAG_EN
    check("clear_nan_flag", 48'(nan_flag), 48'h0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 48'(out_valid), 48'h0);
    check("rst_in_ready", 48'(in_ready), 48'h0);
    check("rst_y", 48'(y), 48'h0);
    check("rst_count", 48'(count), 48'h0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 48'(in_ready), 48'h1);

    // mode 0, single element: (3-1)^2 = 4
    push_exp(32'h40800000, 16'd1);
    send(32'h40400000, 32'h3F800000, 1'b1, 1'b0, 1'b0);
    wait_done();
    release_chk();

    // mode 0, three elements: 4 + 4 + 0 = 8, then hold the result
    push_exp(32'h41000000, 16'd3);
    send(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    send(32'h40A00000, 32'h40A00000, 1'b1, 1'b0, 1'b0);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_y", 48'(y), 48'h41000000);
      check("hold_count", 48'(count), 48'd3);
      check("hold_out_valid", 48'(out_valid), 48'h1);
      check("hold_in_ready", 48'(in_ready), 48'h0);
      // offered while not ready: must be ignored
      a = 32'h40A00000; b = 32'h0; in_last = 1'b1; in_valid = 1'b1;
    end
    in_valid = 1'b0;
    release_chk();

    // mode 1 via override: |1-3| + |2-0.5| = 3.5
    push_exp(32'h40600000, 16'd2);
    send(32'h3F800000, 32'h40400000, 1'b0, 1'b1, 1'b1);
    send(32'h40000000, 32'h3F000000, 1'b1, 1'b1, 1'b1);
    wait_done();
    release_chk();

    // reset while the multiply is in flight, then a fresh one-term vector
    send(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_count", 48'(count), 48'h0);
    push_exp(32'h3F800000, 16'd1);
    send(32'h40000000, 32'h3F800000, 1'b1, 1'b0, 1'b0);
    wait_done();
    release_chk();

`ifdef SSE_ACCUM_NAN_FLAG_EN
    push_exp(32'h7FC00000, 16'd2);
    send(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b1, 1'b0, 1'b0);
    wait_done();
    check("nan_flag_set", 48'(nan_flag), 48'h1);
    release_chk();
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 48'(sb_q.size()), 48'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sse_accum_n.md
SSE_ACCUM_N -- requirements
Module: sse_accum_n

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the element counter width (range 4..32).
REQ-002 The block SHALL have parameter MODE_DEF, default 0, giving the mode used when mode_ovr=0 (0=sum of squared error, 1=sum of absolute error).
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, element pair offered.
REQ-006 The block SHALL have port in_ready, output, 1, element pair accepted this cycle when in_valid=1.
REQ-007 The block SHALL have ports a and b, input, 32 each, IEEE-754 single operands.
REQ-008 The block SHALL have port in_last, input, 1, marks the final element of a vector.
REQ-009 The block SHALL have ports mode_ovr and mode, input, 1 each; mode_ovr=1 selects mode, mode_ovr=0 selects MODE_DEF.
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, result consumed.
REQ-012 The block SHALL have port y, output, 32, accumulated error (IEEE single).
REQ-013 The block SHALL have port count, output, CNT_W, number of elements accumulated.

Function
REQ-014 The block SHALL instantiate adder_fp twice (subtract: op=1; accumulate: op=0) and multiplier_fp once, each driven by a one-cycle start pulse and completed on its ready pulse.
REQ-015 The FSM SHALL have states IDLE, SUB, TERM, ACC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; on in_valid&&in_ready the block SHALL latch a, b, in_last and the effective mode, pulse the subtract start and go to SUB.
REQ-017 In SUB, on subtract ready, the block SHALL latch d=a-b; in mode 0 it SHALL pulse multiplier start with d,d and go to TERM; in mode 1 it SHALL set term=d with bit31 cleared and go directly to ACC with the accumulate start pulsed.
REQ-018 In TERM, on multiplier ready, the block SHALL latch term and pulse accumulate start with acc,term, then go to ACC.
REQ-019 In ACC, on accumulate ready, the block SHALL set acc<=sum and count<=count+1; it SHALL go to DONE if the latched last is set, else to IDLE.
REQ-020 count SHALL saturate at all-ones; acc SHALL keep accumulating after count saturates.
REQ-021 In DONE, out_valid SHALL be 1 and y and count SHALL be held stable.
REQ-022 When out_ready=1 in DONE, the block SHALL clear acc and count to 0 and return to IDLE; in_ready SHALL rise the cycle after.
REQ-023 No start pulse SHALL be issued while the target unit reports busy; the block SHALL hold the pulse pending until busy=0.
REQ-024 in_valid while in_ready=0 SHALL be ignored, and in_last on the first element SHALL yield a one-term result.
REQ-025 out_valid SHALL rise exactly one cycle after the final accumulate ready.
REQ-026 y SHALL equal acc at all times; y SHALL be 0 between vectors.

Reset
REQ-027 On rst, outputs SHALL be out_valid=0, in_ready=0 (in_ready=1 from the first cycle after rst is released), y=0, count=0, with state IDLE and all start pulses at 0.
REQ-028 rst mid-operation SHALL abandon the element; a ready pulse from any unit arriving after reset SHALL be ignored.

Configuration
REQ-029 With macro SSE_ACCUM_NAN_FLAG_EN defined, the block SHALL have output nan_flag (1 bit), set sticky when any term or acc is NaN (exponent 0xFF, mantissa nonzero), valid with out_valid, and cleared with acc.
REQ-030 Without SSE_ACCUM_NAN_FLAG_EN, the nan_flag port and its logic SHALL be absent, and the behaviour SHALL otherwise be identical.

Verification
REQ-031 A bench SHALL cover mode 0 single element a=0x40400000 (3.0), b=0x3F800000 (1.0), last=1 -> out_valid with y=0x40800000 (4.0), count=1.
REQ-032 A bench SHALL cover mode 0 with pairs (3,1), (1,3), (5,5), last on the third -> y=0x41000000 (8.0), count=3.
REQ-033 A bench SHALL cover mode 1 (mode_ovr=1) with pairs (1,3), (2,0.5), last on the second -> y=0x40600000 (3.5), count=2.
REQ-034 A bench SHALL cover out_ready held 0 for 10 cycles -> out_valid and y stable, in_ready=0; then out_ready=1 -> next cycle y=0, count=0, in_ready=1.
REQ-035 A bench SHALL cover rst asserted during TERM, then a single pair (2,1) with last=1 -> y=0x3F800000 (1.0), count=1, with no carry-over.
REQ-036 A bench SHALL cover, with SSE_ACCUM_NAN_FLAG_EN, a=0x7FC00000 then a valid pair with last -> nan_flag=1 at out_valid, and nan_flag=0 after out_ready.
